// File: rtl/strip_frame_loader.sv
// rtl/strip_frame_loader.sv - double-buffered LED strip frame loader with encoder handshake
module strip_frame_loader #(
  parameter int LENGTH      = 4,
  parameter int ARM_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [23:0]          pix_data,
  input  logic                 pix_last,
  input  logic                 enc_busy,
  output logic [LENGTH*24-1:0] strip,
  output logic                 frame_start,
  output logic                 len_err,
  output logic [15:0]          frames_sent
);

  // arm_cnt only needs to reach ARM_TIMEOUT-1
  localparam int AW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    BUSY
  } swap_state_t;

  logic [LENGTH*24-1:0] back_buf;
  logic [7:0]           idx;
  logic                 back_full;
  logic                 accept;
  logic                 at_end;
  logic                 early_last;
  logic                 swap;
  swap_state_t          state;
  swap_state_t          state_nxt;
  logic [AW-1:0]        arm_cnt;
  logic [AW-1:0]        arm_cnt_nxt;

  // A full back buffer blocks the stream until the swap frees it, so
  // acceptance and swap can never fall on the same edge.
  assign pix_ready  = !back_full && !reset;
  assign accept     = pix_valid && pix_ready;
  assign at_end     = (idx == 8'(LENGTH - 1));
  assign early_last = pix_last && !at_end;

  // Back-buffer fill: write the slot, zero the tail on a short frame,
  // flag a length error when pix_last and the final slot disagree.
  always_ff @(posedge clk) begin
    if (reset) begin
      back_buf  <= '0;
      idx       <= '0;
      back_full <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (swap) begin
        back_full <= 1'b0;
      end
      if (accept) begin
        for (int i = 0; i < LENGTH; i++) begin
          if (8'(i) == idx) begin
            back_buf[24*i +: 24] <= pix_data;
          end else if (early_last && (8'(i) > idx)) begin
            back_buf[24*i +: 24] <= '0;
          end
        end
        if (pix_last || at_end) begin
          back_full <= 1'b1;
          idx       <= '0;
          len_err   <= (pix_last != at_end);
        end else begin
          idx <= idx + 8'd1;
        end
      end
    end
  end

  // Swap FSM next-state: swap only from IDLE; ARMED waits for the encoder
  // to pick the frame up, giving up after ARM_TIMEOUT cycles.
  always_comb begin
    state_nxt   = state;
    arm_cnt_nxt = arm_cnt;
    swap        = 1'b0;
    case (state)
      IDLE: begin
        if (back_full && !enc_busy) begin
          swap        = 1'b1;
          state_nxt   = ARMED;
          arm_cnt_nxt = '0;
        end
      end
      ARMED: begin
        if (enc_busy) begin
          state_nxt = BUSY;
        end else if (arm_cnt == AW'(ARM_TIMEOUT - 1)) begin
          state_nxt = IDLE;
        end else begin
          arm_cnt_nxt = arm_cnt + AW'(1);
        end
      end
      BUSY: begin
        if (!enc_busy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Swap FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      arm_cnt <= '0;
    end else begin
      state   <= state_nxt;
      arm_cnt <= arm_cnt_nxt;
    end
  end

  // Front buffer, frame_start pulse and frame counter, all updated on the swap edge
  always_ff @(posedge clk) begin
    if (reset) begin
      strip       <= '0;
      frame_start <= 1'b0;
      frames_sent <= '0;
    end else begin
      frame_start <= swap;
      if (swap) begin
        strip       <= back_buf;
        frames_sent <= frames_sent + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_strip_frame_loader.sv
// tb/tb_strip_frame_loader.sv - randomized and directed bench for strip_frame_loader against a frame-level model
module tb_strip_frame_loader;

  localparam int LENGTH      = 4;
  localparam int ARM_TIMEOUT = 8;
  localparam int W           = LENGTH * 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [23:0]   pix_data = '0;
  logic          pix_last = 1'b0;
  logic          enc_busy = 1'b0;
  logic [W-1:0]  strip;
  logic          frame_start;
  logic          len_err;
  logic [15:0]   frames_sent;

  int n_vec = 0;
  int n_err = 0;

  // model state: pixels of the frame in progress, the completed frame waiting
  // for a swap, and whether the encoder still owns the previous frame
  logic [23:0]   m_cur[$];
  logic [W-1:0]  m_pend = '0;
  logic [W-1:0]  m_strip = '0;
  logic [15:0]   m_count = '0;
  bit            m_full = 0;
  bit            m_fs = 0;
  bit            m_le = 0;
  bit            m_ready = 0;
  bit            m_wait = 0;
  bit            m_seen = 0;
  int            m_t = 0;

  always #10 clk = ~clk;

  strip_frame_loader #(
    .LENGTH(LENGTH),
    .ARM_TIMEOUT(ARM_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .pix_last(pix_last),
    .enc_busy(enc_busy),
    .strip(strip),
    .frame_start(frame_start),
    .len_err(len_err),
    .frames_sent(frames_sent)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock: drive at negedge, advance the model at posedge, compare 1ns later
  task automatic step(input logic r, input logic v, input logic [23:0] d, input logic l, input logic b);
    bit do_swap;
    bit do_acc;
    @(negedge clk);
    reset     = r;
    pix_valid = v;
    pix_data  = d;
    pix_last  = l;
    enc_busy  = b;
    @(posedge clk);
    if (r) begin
      m_cur.delete();
      m_pend  = '0;
      m_strip = '0;
      m_count = '0;
      m_full  = 0;
      m_fs    = 0;
      m_le    = 0;
      m_wait  = 0;
      m_seen  = 0;
      m_t     = 0;
    end else begin
      do_swap = !m_wait && m_full && !b;
      do_acc  = v && !m_full;
      m_fs    = do_swap;
      m_le    = 0;
      if (m_wait) begin
        if (!m_seen) begin
          if (b) begin
            m_seen = 1;
          end else begin
            m_t++;
            if (m_t == ARM_TIMEOUT) m_wait = 0;
          end
        end else if (!b) begin
          m_wait = 0;
        end
      end
      if (do_swap) begin
        m_strip = m_pend;
        m_count = m_count + 16'd1;
        m_full  = 0;
        m_wait  = 1;
        m_seen  = 0;
        m_t     = 0;
      end
      if (do_acc) begin
        m_cur.push_back(d);
        if (l || m_cur.size() == LENGTH) begin
          m_le   = !(l && m_cur.size() == LENGTH);
          m_pend = '0;
          foreach (m_cur[k]) m_pend[24*k +: 24] = m_cur[k];
          m_cur.delete();
          m_full = 1;
        end
      end
    end
    m_ready = !m_full && !r;
    #1;
    chk("pix_ready", W'(pix_ready), W'(m_ready));
    chk("strip", strip, m_strip);
    chk("frame_start", W'(frame_start), W'(m_fs));
    chk("len_err", W'(len_err), W'(m_le));
    chk("frames_sent", W'(frames_sent), W'(m_count));
  endtask

  task automatic px(input logic [23:0] d, input logic l);
    step(1'b0, 1'b1, d, l, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  // idle until the DUT pulses frame_start; n is the number of steps taken
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    if (frame_start !== 1'b1) chk("wait_fs_timeout", W'(frame_start), W'(1));
  endtask

  initial begin
    int n;
    int enc_dly;
    int enc_len;
    logic r, v, l, b;
    logic [23:0] d;

    // reset state
    step(1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("rst_strip", strip, '0);
    chk("rst_count", W'(frames_sent), '0);
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("rst_ready_after", W'(pix_ready), W'(1));

    // full 4-pixel frame, swap one edge after completion
    px(24'hFF0000, 1'b0);
    px(24'h00FF00, 1'b0);
    px(24'h0000FF, 1'b0);
    px(24'hFFFFFF, 1'b1);
    chk("f1_no_fs_yet", W'(frame_start), W'(0));
    chk("f1_ready_low", W'(pix_ready), W'(0));
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("f1_fs", W'(frame_start), W'(1));
    chk("f1_strip", strip, 96'hFFFFFF_0000FF_00FF00_FF0000);
    chk("f1_count", W'(frames_sent), W'(1));

    // encoder never responds: next frame waits out the arm timeout
    px(24'h111111, 1'b0);
    px(24'h222222, 1'b0);
    px(24'h333333, 1'b0);
    px(24'h444444, 1'b1);
    wait_fs(n);
    chk("timeout_gap", W'(4 + n), W'(ARM_TIMEOUT + 1));
    chk("f2_strip", strip, 96'h444444_333333_222222_111111);

    // short frame: tail cleared, single len_err pulse
    px(24'hAAAAAA, 1'b0);
    px(24'hBBBBBB, 1'b1);
    chk("short_len_err", W'(len_err), W'(1));
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("short_len_err_pulse", W'(len_err), W'(0));
    wait_fs(n);
    chk("short_low", W'(strip[47:0]), W'(48'hBBBBBB_AAAAAA));
    chk("short_high", W'(strip[95:48]), W'(0));
    idle(10);

    // frame completes while the encoder is busy: held until enc_busy falls
    step(1'b0, 1'b1, 24'h010203, 1'b0, 1'b1);
    step(1'b0, 1'b1, 24'h040506, 1'b0, 1'b1);
    step(1'b0, 1'b1, 24'h070809, 1'b0, 1'b1);
    step(1'b0, 1'b1, 24'h0A0B0C, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 24'h0, 1'b0, 1'b1);
    chk("busy_ready_low", W'(pix_ready), W'(0));
    chk("busy_strip_held", strip, {48'h0, 48'hBBBBBB_AAAAAA});
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("busy_release_fs", W'(frame_start), W'(1));
    chk("busy_release_strip", strip, 96'h0A0B0C_070809_040506_010203);
    idle(10);

    // reset mid-frame discards the partial frame
    px(24'hDEAD01, 1'b0);
    px(24'hDEAD02, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("mid_rst_strip", strip, '0);
    chk("mid_rst_count", W'(frames_sent), '0);
    chk("mid_rst_fs", W'(frame_start), '0);
    chk("mid_rst_le", W'(len_err), '0);
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("mid_rst_ready", W'(pix_ready), W'(1));
    px(24'h0000A1, 1'b0);
    px(24'h0000A2, 1'b0);
    px(24'h0000A3, 1'b0);
    px(24'h0000A4, 1'b1);
    wait_fs(n);
    chk("post_rst_strip", strip, 96'h0000A4_0000A3_0000A2_0000A1);
    idle(10);

    // counter wrap
    @(negedge clk);
    force dut.frames_sent = 16'hFFFF;
    #1;
    release dut.frames_sent;
    m_count = 16'hFFFF;
    px(24'h123456, 1'b0);
    px(24'h234567, 1'b0);
    px(24'h345678, 1'b0);
    px(24'h456789, 1'b1);
    wait_fs(n);
    chk("wrap_count", W'(frames_sent), W'(0));

    // randomized traffic with a loosely behaved encoder and occasional resets
    enc_dly = -1;
    enc_len = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_fs) begin
        enc_dly = $urandom_range(0, 11);
        enc_len = $urandom_range(1, 15);
      end
      if (enc_dly > 0) begin
        b = 1'b0;
        enc_dly--;
      end else if (enc_dly == 0 && enc_len > 0) begin
        b = 1'b1;
        enc_len--;
        if (enc_len == 0) enc_dly = -1;
      end else begin
        b = ($urandom_range(0, 29) == 0);
      end
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 5) == 0);
      d = 24'($urandom);
      step(r, v, d, l, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
